// File: rtl/e_digit_sequencer_pkg.sv
// Shared types for the e digit sequencer: FSM states, error codes and a
// small saturating-increment helper.
package e_digit_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC_GO,
    S_CALC_WAIT,
    S_CONV_GO,
    S_CONV_WAIT,
    S_DRAIN,
    S_FAIL
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_FIFO_OVF = 2'd2;
  localparam logic [1:0] ERR_CNT_OVF  = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/e_digit_sequencer_digit_fifo.sv
// Synchronous digit FIFO with extra-MSB pointers for full/empty; flush resets
// both pointers and wins over push/pop in the same cycle.
module digit_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A pop frees the head slot this cycle, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/e_digit_sequencer.sv
// Sequences one e computation run: e_calc, then convert_to_10, buffering the
// decimal digits and streaming them out over valid/ready.
//   state     | meaning
//   IDLE      | waiting for go
//   CALC_GO   | calc_start pulse
//   CALC_WAIT | waiting for calc_done (timed)
//   CONV_GO   | conv_start pulse
//   CONV_WAIT | capturing digits until conv_done (timed per digit)
//   DRAIN     | emptying FIFO, then run_done
//   FAIL      | error latched, FIFO flushed, back to IDLE
module e_digit_sequencer
  import e_digit_sequencer_pkg::*;
#(
  parameter int DIGIT_W        = 4,
  parameter int FIFO_DEPTH     = 16,
  parameter int MAX_DIGITS     = 128,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               abort,
  output logic               calc_start,
  input  logic               calc_done,
  output logic               conv_start,
  input  logic               conv_valid,
  input  logic [DIGIT_W-1:0] conv_digit,
  input  logic               conv_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT_W-1:0] out_digit,
  output logic               busy,
  output logic               run_done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [7:0]         digit_count
);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [CNT_W-1:0]   n_acc;
  logic               fifo_flush;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [DIGIT_W-1:0] fifo_dout;
  logic [LVL_W-1:0]   fifo_level;
  logic               fail_now;
  logic [1:0]         fail_code;

  assign out_valid = !fifo_empty;
  assign out_digit = fifo_empty ? '0 : fifo_dout;
  assign fifo_pop  = out_valid && out_ready;

  // Error priority: FIFO overflow, then digit-count overflow, then timeout.
  always_comb begin
    fifo_push = 1'b0;
    fail_now  = 1'b0;
    fail_code = ERR_NONE;
    if (!abort && state == S_CONV_WAIT && conv_valid) begin
      if (fifo_full && !fifo_pop) begin
        fail_now  = 1'b1;
        fail_code = ERR_FIFO_OVF;
      end else if (n_acc == CNT_MAX) begin
        fail_now  = 1'b1;
        fail_code = ERR_CNT_OVF;
      end else begin
        fifo_push = 1'b1;
      end
    end
    if (!abort && !fail_now && timer == '0 &&
        ((state == S_CALC_WAIT && !calc_done) ||
         (state == S_CONV_WAIT && !conv_valid && !conv_done))) begin
      fail_now  = 1'b1;
      fail_code = ERR_TIMEOUT;
    end
  end

  assign fifo_flush = abort || (state == S_IDLE && go) || fail_now;

  digit_fifo #(
    .WIDTH (DIGIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (conv_digit),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      n_acc       <= '0;
      calc_start  <= 1'b0;
      conv_start  <= 1'b0;
      busy        <= 1'b0;
      run_done    <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
      digit_count <= '0;
    end else begin
      calc_start <= 1'b0;
      conv_start <= 1'b0;
      run_done   <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (go) begin
              state       <= S_CALC_GO;
              calc_start  <= 1'b1;
              busy        <= 1'b1;
              err         <= 1'b0;
              err_code    <= ERR_NONE;
              digit_count <= '0;
              n_acc       <= '0;
            end
          end
          S_CALC_GO: begin
            state <= S_CALC_WAIT;
            timer <= TMR_LOAD;
          end
          S_CALC_WAIT: begin
            if (calc_done) begin
              state      <= S_CONV_GO;
              conv_start <= 1'b1;
            end else if (fail_now) begin
              state    <= S_FAIL;
              err      <= 1'b1;
              err_code <= fail_code;
            end else begin
              timer <= timer - TMR_ONE;
            end
          end
          S_CONV_GO: begin
            state <= S_CONV_WAIT;
            timer <= TMR_LOAD;
          end
          S_CONV_WAIT: begin
            if (fail_now) begin
              state    <= S_FAIL;
              err      <= 1'b1;
              err_code <= fail_code;
            end else begin
              if (fifo_push) begin
                n_acc       <= n_acc + CNT_ONE;
                digit_count <= sat_inc8(digit_count);
                timer       <= TMR_LOAD;
              end else if (timer != '0) begin
                timer <= timer - TMR_ONE;
              end
              if (conv_done) state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (fifo_level == '0) begin
              state    <= S_IDLE;
              run_done <= 1'b1;
              busy     <= 1'b0;
            end
          end
          S_FAIL: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/e_digit_sequencer.md
Name: e_digit_sequencer

Overview:
Top-level controller that sequences one full e computation run. It pulses e_calc start and waits for done, then pulses convert_to_10 start. It captures the serial decimal digits into a small FIFO and streams them to a downstream consumer over a valid/ready handshake. It replaces bench-driven sequencing so the chain can run unattended on the FPGA, with timeout, overflow and abort handling.

Parameters:
DIGIT_W, 4, width of one decimal digit from convert_to_10
FIFO_DEPTH, 16, digit buffer entries (power of 2, >=2)
MAX_DIGITS, 128, maximum digits accepted per run; one more is an error
TIMEOUT_CYCLES, 100000, maximum cycles allowed in each wait state (1 ms at 100 MHz)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
go  in  1  run request, sampled only in IDLE
abort  in  1  synchronous abort; flushes the FIFO and returns to IDLE
calc_start  out  1  one-cycle start pulse to e_calc
calc_done  in  1  e_calc done (level or pulse)
conv_start  out  1  one-cycle start pulse to convert_to_10
conv_valid  in  1  converter digit strobe; no backpressure
conv_digit  in  DIGIT_W  converter digit, valid with conv_valid
conv_done  in  1  converter finished
out_valid  out  1  digit available to consumer
out_ready  in  1  consumer accepts when out_valid&&out_ready
out_digit  out  DIGIT_W  head-of-FIFO digit
busy  out  1  high in any state other than IDLE
run_done  out  1  one-cycle pulse on successful completion
err  out  1  sticky error flag, cleared by the next accepted go
err_code  out  2  0 none, 1 timeout, 2 FIFO overflow, 3 digit-count overflow
digit_count  out  8  digits accepted this run (saturates at 255)

Behaviour:
- Reset (async, rst=1): state IDLE; FIFO empty; all outputs 0; digit_count 0; err 0; err_code 0.
- FSM states: IDLE, CALC_GO, CALC_WAIT, CONV_GO, CONV_WAIT, DRAIN, FAIL.
- IDLE: go=1 -> CALC_GO. On that transition clear err, err_code and digit_count, and flush the FIFO.
- CALC_GO: calc_start=1 for exactly one cycle -> CALC_WAIT. Start-to-pulse latency is 1 cycle after go is sampled.
- CALC_WAIT: calc_done=1 -> CONV_GO. Wait counter reaching TIMEOUT_CYCLES -> FAIL with code 1.
- CONV_GO: conv_start=1 for one cycle -> CONV_WAIT.
- CONV_WAIT:
  - conv_valid pushes conv_digit into the FIFO and increments digit_count.
  - conv_done -> DRAIN. If conv_valid and conv_done coincide, the digit is still pushed.
  - Timeout -> FAIL code 1. The wait counter restarts on every accepted digit.
- Pushes during CONV_WAIT:
  - Push when FIFO full and no pop in the same cycle: digit dropped -> FAIL code 2.
  - Simultaneous push and pop while full is legal.
  - The (MAX_DIGITS+1)th push -> FAIL code 3; that digit is not stored.
- DRAIN: keep popping; when the FIFO is empty, pulse run_done for one cycle -> IDLE.
- FAIL: err=1; err_code holds. The FIFO is flushed on entry, out_valid=0. -> IDLE on the next cycle; err stays sticky. The first error wins when several occur in the same cycle, in priority 2 > 3 > 1.
- Output side:
  - out_valid = FIFO not empty; out_digit = head entry, combinational from the FIFO.
  - Pop on out_valid&&out_ready. Pops are allowed in CONV_WAIT and DRAIN.
  - out_digit must stay stable while out_valid=1 and out_ready=0.
- abort=1 in any state: flush the FIFO, drop calc_start/conv_start, -> IDLE next cycle. No err, no run_done. abort overrides go in the same cycle.
- go while busy is ignored. conv_valid outside CONV_WAIT is ignored.
- FIFO: pointers one bit wider than log2(FIFO_DEPTH) for full/empty detection; wrap-around is natural modulo.

Decomposition:
- Shared package/header: state encodings, err_code constants (ERR_NONE, ERR_TIMEOUT, ERR_FIFO_OVF, ERR_CNT_OVF).
- Sub-module digit_fifo (sync FIFO).
  - Params: width, depth.
  - Ports: clk, rst, flush, push, din, pop, dout, empty, full, count.

Test Plan:
- Nominal: go; calc_done after 50 cycles; 10 digits 2,7,1,8,2,8,1,8,2,8 then conv_done; out_ready=1 -> calc_start 1 cycle after go; digits emerge in order; run_done once; digit_count=10; err=0.
- Backpressure: 16 digits with out_ready=0 until conv_done, then out_ready=1 -> all 16 emitted in order, no error. A 17th digit before any pop -> err=1, err_code=2, out_valid=0 next cycle.
- Timeout: TIMEOUT_CYCLES=100, calc_done never asserted -> FAIL, err_code=1, busy drops; conv_start never pulses.
- Count limit: MAX_DIGITS=8, 9 digits, out_ready=1 -> err_code=3; exactly 8 digits output before the flush.
- Abort/reset: abort mid-CONV_WAIT with 5 digits buffered -> IDLE, out_valid=0, err=0, no run_done. rst asserted mid-run (async, not clock-aligned) -> all outputs 0 immediately. A later go runs normally.
- Edge: conv_valid and conv_done in the same cycle as the last digit -> digit delivered; go during busy ignored.
